wb_mem_arbiter: RTL

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter_pkg.sv | 35 +++
 rtl/wb_arb_timer.sv | 34 +++
 rtl/wb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone memory arbiter.
//   - default address/data width and stall timeout
//   - width of the stall counter
//   - arbiter FSM state encoding
//   - helper turning a state into the one-hot grant vector
package wb_mem_arbiter_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    // The stall counter is 16 bits wide, so TIMEOUT may range over 1..65535.
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    // Bit 0 is m0 (CPU bridge) and bit 1 is m1 (SD DMA). The result is 00
    // in IDLE and in ABORT.
    function automatic logic [1:0] grant_onehot(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Stall counter for the Wishbone memory arbiter.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   clear    : clears the count; takes priority over count_en
//   count_en : the current cycle is a stalled strobe
//   expired  : high combinationally in the stalled cycle whose count equals
//              TIMEOUT-1. That cycle is the TIMEOUT-th consecutive stall.
module wb_arb_timer
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [STALL_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + STALL_CNT_W'(1);
        end
    end

    // The count holds the number of stalled cycles seen before this one.
    // When the count equals TIMEOUT-1, this stall is the last one allowed.
    assign expired = count_en && (cnt_q == STALL_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single memory slave.
//   m0 is the CPU bridge and m1 is the SD card DMA master.
//
// Ports
//   wb_clk_i, wb_rst_i          : clock; synchronous active-high reset
//   mN_adr/dat/sel/we/cyc/stb/cti/bte_i : master N request
//   mN_dat_o/ack_o/err_o        : master N response (0 unless N owns the bus)
//   s_adr/dat/sel/we/cyc/stb/cti/bte_o  : shared slave request
//   s_dat_i/ack_i/err_i         : slave response
//   grant_o                     : one-hot owner {m1,m0}; 00 when nobody owns
//   timeout_o                   : one-cycle pulse when a stalled cycle aborts
//   state_o                     : current FSM state, for debug
//
// Handshake: a transfer is offered while cyc and stb are both high. It
// completes in the cycle where the slave raises ack (or err) with the
// strobe still high. The arbiter adds no handshake of its own: the owner's
// request passes combinationally to the slave, and the slave's response
// passes combinationally back to the owner.
//
// A master owns the bus from its grant until it drops cyc. Ownership
// ignores stb and cti, so a burst is never split. Once the owner releases
// the bus, there is always at least one IDLE cycle before the next grant.
// A strobe stalled for TIMEOUT consecutive cycles is ended with err to the
// owner. The FSM then waits in ABORT, with the slave port quiet, until that
// master drops cyc.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // master 0: CPU bridge
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    // master 1: SD card DMA
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    // shared slave
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    // status
    output logic [1:0]    grant_o,
    output logic          timeout_o,
    output arb_state_t    state_o
);

    arb_state_t state_q, state_d;
    // 1'b1 means m1 was granted most recently. The reset value of 1 lets m0
    // win the first tie.
    logic       last_grant_q, last_grant_d;

    logic own0, own1, owning;
    logic stall_en, stall_clr, expired;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Round-robin: grant the master not served last time.
                    if (last_grant_q) begin
                        state_d      = ST_OWN0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = ST_OWN1;
                        last_grant_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d      = ST_OWN0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = ST_OWN1;
                    last_grant_d = 1'b1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                // last_grant_q still names the master whose cycle was aborted.
                if (last_grant_q ? !m1_cyc_i : !m0_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ownership as seen by the outputs. Reset forces the bus quiet in the
    // reset cycle itself, whatever state the register still holds.
    assign own0   = (state_q == ST_OWN0) && !wb_rst_i;
    assign own1   = (state_q == ST_OWN1) && !wb_rst_i;
    assign owning = own0 || own1;

    // ------------------------------------------------------------------
    // Request path: the owner's request goes to the slave combinationally.
    // The slave sees nothing when no master owns the bus.
    // ------------------------------------------------------------------
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (own0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_cyc_i && m0_stb_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (own1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_cyc_i && m1_stb_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

    // ------------------------------------------------------------------
    // Stall timer: counts strobed cycles that get neither ack nor err.
    // ------------------------------------------------------------------
    assign stall_en  = owning && s_stb_o && !s_ack_i && !s_err_i;
    assign stall_clr = !owning || !s_stb_o || s_ack_i || s_err_i;

    wb_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clear    (stall_clr),
        .count_en (stall_en),
        .expired  (expired)
    );

    // ------------------------------------------------------------------
    // Response path: only the owner sees the slave. ack and err pass
    // through together when both are raised. expired can only be high in
    // a cycle with neither ack nor err, so the abort err never collides
    // with a real response.
    // ------------------------------------------------------------------
    assign m0_dat_o  = own0 ? s_dat_i : '0;
    assign m0_ack_o  = own0 && s_ack_i;
    assign m0_err_o  = own0 && (s_err_i || expired);

    assign m1_dat_o  = own1 ? s_dat_i : '0;
    assign m1_ack_o  = own1 && s_ack_i;
    assign m1_err_o  = own1 && (s_err_i || expired);

    assign timeout_o = expired;
    assign grant_o   = wb_rst_i ? 2'b00 : grant_onehot(state_q);
    assign state_o   = state_q;

endmodule
